// File: rtl/ts_capture_pkg.sv
// Shared constants for the timestamp capture block: default geometry and
// the packed {epoch, count} timestamp width.
package ts_capture_pkg;

   localparam int DEF_DEPTH   = 4;
   localparam int DEF_EPOCH_W = 16;
   localparam int TS_W        = DEF_EPOCH_W + 32;

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through FIFO for captured timestamps. Pointers carry one
// extra bit so full and empty are distinguishable; flush empties it in one cycle.
module ts_fifo
   import ts_capture_pkg::*;
#(
   parameter int W     = TS_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic                     valid,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_r [DEPTH];
   logic [AW:0]  wr_ptr_r;
   logic [AW:0]  rd_ptr_r;
   logic [AW:0]  level_r;
   logic [AW:0]  level_next_s;
   logic         valid_r;
   logic         full_r;

   // Next occupancy; a push and pop together cancel out.
   always_comb begin
      level_next_s = level_r + (AW + 1)'(push) - (AW + 1)'(pop);
   end

   // Pointer, occupancy and status registers.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
         valid_r  <= 1'b0;
         full_r   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         level_r <= level_next_s;
         valid_r <= (level_next_s != '0);
         full_r  <= (level_next_s == (AW + 1)'(DEPTH));
      end
   end

   // Storage write; at full with a pop the tail slot is the one being vacated.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) begin
         mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
   end

   assign dout  = mem_r[rd_ptr_r[AW-1:0]];
   assign valid = valid_r;
   assign level = level_r;
   assign full  = full_r;

endmodule

// File: rtl/ts_capture.sv
// Timestamps rising edges of an asynchronous trigger with {epoch, count},
// where the epoch counts 32-bit timer wraps, and queues them in a FIFO.
module ts_capture
   import ts_capture_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int EPOCH_W = DEF_EPOCH_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     ena,
   input  logic                     trig_in,
   input  logic [31:0]              count,
   input  logic                     pulse_full,
   output logic                     ts_valid,
   input  logic                     ts_ready,
   output logic [EPOCH_W+31:0]      ts_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   logic               sync1_r;
   logic               sync2_r;
   logic               dly_r;
   logic [EPOCH_W-1:0] epoch_r;
   logic [EPOCH_W-1:0] epoch_next_s;
   logic               overflow_r;
   logic               event_s;
   logic               pop_s;
   logic               push_s;
   logic               drop_s;
   logic               full_s;
   logic [EPOCH_W+31:0] ts_in_s;

   // Event detection and push/drop arbitration; a pop frees a slot at full.
   always_comb begin
      epoch_next_s = epoch_r + {{(EPOCH_W - 1){1'b0}}, pulse_full};
      event_s      = sync2_r & ~dly_r & ena;
      pop_s        = ts_valid & ts_ready;
      push_s       = event_s & (~full_s | pop_s);
      drop_s       = event_s & full_s & ~pop_s;
      ts_in_s      = {epoch_next_s, count};
   end

   // Trigger synchronizer and edge register; clr deliberately leaves these alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         dly_r   <= 1'b0;
      end else begin
         sync1_r <= trig_in;
         sync2_r <= sync1_r;
         dly_r   <= sync2_r;
      end
   end

   // Wrap-epoch counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         epoch_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         epoch_r <= epoch_next_s;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   ts_fifo #(
      .W     (EPOCH_W + 32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clr),
      .push  (push_s),
      .pop   (pop_s),
      .din   (ts_in_s),
      .valid (ts_valid),
      .dout  (ts_data),
      .level (level),
      .full  (full_s)
   );

   assign overflow = overflow_r;

endmodule

// File: tb/tb_ts_capture.sv
// Bench for ts_capture: directed scenarios then random traffic, all checked
// against a queue-based timestamp model.
module tb_ts_capture;

   localparam int DEPTH   = 4;
   localparam int EPOCH_W = 16;
   localparam int TSW     = EPOCH_W + 32;
   localparam int LW      = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            clr;
   logic            ena;
   logic            trig_in;
   logic [31:0]     count;
   logic            pulse_full;
   logic            ts_valid;
   logic            ts_ready;
   logic [TSW-1:0]  ts_data;
   logic [LW-1:0]   level;
   logic            overflow;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: queued timestamps, epoch, sticky flag, trigger samples.
   logic [TSW-1:0]     mq[$];
   logic [EPOCH_W-1:0] m_ep;
   logic               m_ov;
   logic               h1, h2, h3;

   always #5 clk = ~clk;

   ts_capture #(.DEPTH(DEPTH), .EPOCH_W(EPOCH_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .ena        (ena),
      .trig_in    (trig_in),
      .count      (count),
      .pulse_full (pulse_full),
      .ts_valid   (ts_valid),
      .ts_ready   (ts_ready),
      .ts_data    (ts_data),
      .level      (level),
      .overflow   (overflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: advance the model with the applied inputs, then compare.
   task automatic tick();
      logic               ev;
      logic               pop;
      logic               full;
      logic [EPOCH_W-1:0] tag_ep;
      if (rst) begin
         mq.delete();
         m_ep = '0;
         m_ov = 1'b0;
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      end else begin
         ev = h2 & ~h3 & ena;
         if (clr) begin
            mq.delete();
            m_ep = '0;
            m_ov = 1'b0;
         end else begin
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && ts_ready;
            tag_ep = m_ep + EPOCH_W'(pulse_full);
            if (pop) void'(mq.pop_front());
            if (ev) begin
               if (!full || pop) mq.push_back({tag_ep, count});
               else m_ov = 1'b1;
            end
            m_ep = tag_ep;
         end
         h3 = h2; h2 = h1; h1 = trig_in;
      end
      @(posedge clk);
      #1;
      check("ts_valid", 64'(ts_valid), 64'(mq.size() != 0));
      check("level", 64'(level), 64'(mq.size()));
      check("overflow", 64'(overflow), 64'(m_ov));
      if (mq.size() != 0) check("ts_data", 64'(ts_data), 64'(mq[0]));
   endtask

   // Rising trigger whose detection cycle sees the given count/pulse/ready.
   task automatic fire(input logic [31:0] cnt, input logic pf, input logic rdy);
      trig_in = 1'b1;
      tick();
      trig_in = 1'b0;
      tick();
      count = cnt; pulse_full = pf; ts_ready = rdy;
      tick();
      pulse_full = 1'b0; ts_ready = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; ena = 1'b1; trig_in = 1'b0;
      count = 32'd0; pulse_full = 1'b0; ts_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_level", 64'(level), 64'd0);
      check("reset_valid", 64'(ts_valid), 64'd0);
      tick();

      // Basic capture.
      fire(32'd100, 1'b0, 1'b0);
      check("basic_data", 64'(ts_data), 64'({16'd0, 32'd100}));
      check("basic_level", 64'(level), 64'd1);

      // Wrap tagging: event just before and exactly on the wrap strobe.
      do_clr();
      fire(32'hFFFF_FFFF, 1'b0, 1'b0);
      check("prewrap_data", 64'(ts_data), 64'({16'd0, 32'hFFFF_FFFF}));
      do_clr();
      fire(32'd0, 1'b1, 1'b0);
      check("wrap_data", 64'(ts_data), 64'({16'd1, 32'd0}));

      // Fill past full, then drain in order.
      do_clr();
      for (int i = 0; i < 5; i++) fire(32'd10 + 32'(i), 1'b0, 1'b0);
      check("ovf_level", 64'(level), 64'd4);
      check("ovf_flag", 64'(overflow), 64'd1);
      ts_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", 64'(ts_data), 64'({16'd0, 32'd10 + 32'(i)}));
         tick();
      end
      ts_ready = 1'b0;
      check("drained_valid", 64'(ts_valid), 64'd0);

      // Push and pop together at full.
      do_clr();
      for (int i = 0; i < 4; i++) fire(32'd20 + 32'(i), 1'b0, 1'b0);
      fire(32'd24, 1'b0, 1'b1);
      check("fullpp_level", 64'(level), 64'd4);
      check("fullpp_ovf", 64'(overflow), 64'd0);
      ts_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("fullpp_order", 64'(ts_data), 64'({16'd0, 32'd21 + 32'(i)}));
         tick();
      end
      ts_ready = 1'b0;

      // Clear coincident with an event at level 3, with a non-zero epoch.
      do_clr();
      pulse_full = 1'b1;
      tick();
      pulse_full = 1'b0;
      for (int i = 0; i < 3; i++) fire(32'd30 + 32'(i), 1'b0, 1'b0);
      trig_in = 1'b1;
      tick();
      trig_in = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_level", 64'(level), 64'd0);
      check("clr_valid", 64'(ts_valid), 64'd0);
      check("clr_ovf", 64'(overflow), 64'd0);
      fire(32'd55, 1'b0, 1'b0);
      check("clr_epoch", 64'(ts_data), 64'({16'd0, 32'd55}));

      // Disabled capture, then reset mid-drain at level 2.
      do_clr();
      ena = 1'b0;
      fire(32'd60, 1'b0, 1'b0);
      check("ena_off_level", 64'(level), 64'd0);
      ena = 1'b1;
      for (int i = 0; i < 3; i++) fire(32'd70 + 32'(i), 1'b0, 1'b0);
      ts_ready = 1'b1;
      tick();
      check("middrain_level", 64'(level), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0; ts_ready = 1'b0;
      check("rst_level", 64'(level), 64'd0);
      check("rst_valid", 64'(ts_valid), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);

      // Trigger held high across reset release.
      trig_in = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      count = 32'd88;
      tick();
      check("held_trig_level", 64'(level), 64'd1);
      check("held_trig_data", 64'(ts_data), 64'({16'd0, 32'd88}));
      trig_in = 1'b0;

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         trig_in    = 1'($urandom_range(0, 1));
         ena        = ($urandom_range(0, 3) != 0);
         ts_ready   = ($urandom_range(0, 2) == 0);
         pulse_full = ($urandom_range(0, 15) == 0);
         clr        = ($urandom_range(0, 79) == 0);
         rst        = ($urandom_range(0, 199) == 0);
         count      = $urandom;
         tick();
      end
      rst = 1'b0; clr = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ts_capture.md
TS_CAPTURE -- requirements
Module: ts_capture

Interface
REQ-001 Parameter DEPTH, default 4: timestamp FIFO depth, power of two, minimum 2.
REQ-002 Parameter EPOCH_W, default 16: width of the wrap-epoch counter.
REQ-003 clk  input  1  single system clock; 110.592 MHz.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 clr  input  1  synchronous clear, same strobe that drives the 32-bit timer clr.
REQ-006 ena  input  1  capture enable; events while low are ignored.
REQ-007 trig_in  input  1  asynchronous external event; the rising edge is the event.
REQ-008 count  input  32  free-running timer value from the 32-bit timer.
REQ-009 pulse_full  input  1  timer wrap strobe; high for 1 cycle, the cycle count reads 0 after wrap.
REQ-010 ts_valid  output  1  FIFO head valid.
REQ-011 ts_ready  input  1  consumer accepts the head when ts_valid and ts_ready are both high.
REQ-012 ts_data  output  EPOCH_W+32  head timestamp {epoch, count}.
REQ-013 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-015 trig_in SHALL pass through a 2-flop synchronizer, then a third register for edge detect.
REQ-016 An event SHALL be declared in the cycle where the synchronized value is 1 and the delayed value is 0, and ena is high.
REQ-017 trig_in rising before clk edge N SHALL produce the event in cycle N+2, with count sampled in that cycle.
REQ-018 The epoch counter SHALL increment by 1 modulo 2^EPOCH_W on each cycle where pulse_full=1.
REQ-019 The captured epoch SHALL be epoch+pulse_full, so an event coincident with pulse_full is tagged {epoch+1, 0}.
REQ-020 The FIFO SHALL be first-word-fall-through: ts_data shows the head whenever ts_valid=1, and ts_data is don't-care otherwise.
REQ-021 A pop SHALL occur iff ts_valid and ts_ready; a push iff event and (not full or pop in the same cycle).
REQ-022 Simultaneous push and pop SHALL leave level unchanged, including at full.
REQ-023 Simultaneous push and pop at level 1 SHALL present the new entry as head on the next cycle.
REQ-024 An event while full without a pop SHALL be dropped, and overflow SHALL set on the next cycle.
REQ-025 Overflow SHALL stay high until rst or clr.
REQ-026 In a clr cycle, the FIFO SHALL be emptied, epoch set to 0 and overflow set to 0. Any event or pop in that cycle SHALL be discarded. Synchronizer flops SHALL NOT be cleared by clr.
REQ-027 A clr cycle SHALL take priority over events and pops in that cycle.
REQ-028 ts_valid SHALL equal (level != 0), and level SHALL be registered.
REQ-029 ts_data SHALL hold stable while ts_valid=1 and ts_ready=0.
REQ-030 FIFO read and write pointers SHALL wrap modulo DEPTH, with one extra bit to tell full from empty.

Reset
REQ-031 When rst=1 at a clk edge, the following SHALL be set: ts_valid=0, level=0, overflow=0, epoch=0, pointers=0, synchronizer and edge registers=0.
REQ-032 rst SHALL override clr and all other inputs.
REQ-033 A rst in mid-stream SHALL discard all buffered timestamps.
REQ-034 trig_in held high through reset release SHALL produce an event 2 cycles after rst deasserts, because the edge register resets to 0.

Structure
REQ-035 A shared package SHALL hold the TS_W=EPOCH_W+32 width constant and the default DEPTH and EPOCH_W values.
REQ-036 The FIFO SHALL be a sub-module, ts_fifo, parameterized by width and depth, with a synchronous active-high reset and a flush input.
REQ-037 Synchronizer, edge detect and epoch logic SHALL stay in the top level.

Verification
REQ-038 trig_in 0->1 asynchronously with count=100 at the detection cycle: ts_valid rises the next cycle, ts_data={0,100}, level=1.
REQ-039 Drive count FFFFFFFF, then 0 with pulse_full=1, and event in the pulse_full cycle: ts_data={1,0}. An event one cycle earlier gives {0,FFFFFFFF}.
REQ-040 ts_ready=0 and 5 events with DEPTH=4: level=4 and overflow=1 after the 5th event. Draining returns the first 4 timestamps in order.
REQ-041 At full, an event coincident with ts_ready=1: level stays 4, overflow stays 0, and the new timestamp is the last entry read out.
REQ-042 Level 3 with clr and event in the same cycle: next cycle level=0, ts_valid=0, epoch=0, overflow=0, and no entry is written.
REQ-043 ena=0 during an event: no push. Assert rst mid-drain at level 2: level=0 on the next cycle, and all outputs are at reset values.
